pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 102 ++++++++++
 tb/tb_pc_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: priority redirect mux, stall hold and pending-redirect capture.
// Optional misalignment flag on redirect targets is enabled by defining PC_SEQUENCER_MISALIGN_EN.
module pc_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h4000_0000,
  parameter int              NUM_SRC  = 2,
  parameter int              INCR     = 4,
  localparam int             SRC_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic [NUM_SRC-1:0]      redir_valid,
  input  logic [NUM_SRC*XLEN-1:0] redir_pc,
  output logic [XLEN-1:0]         pc_out,
  output logic                    pc_redirect,
  output logic [SRC_W-1:0]        redir_src,
  output logic                    misalign
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   cur_pc, held_pc, pend_pc;
  logic              pend_valid;
  logic              any_redir;
  logic [SRC_W-1:0]  sel;
  logic [XLEN-1:0]   target;

  function automatic logic [XLEN-1:0] seq_next(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INCR);
  endfunction

  // Scan from the lowest priority upward so the lowest set index is left in place.
  always_comb begin
    sel    = '0;
    target = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (redir_valid[i]) begin
        sel    = SRC_W'(i);
        target = redir_pc[i*XLEN +: XLEN];
      end
    end
  end

  assign any_redir = |redir_valid;

  always_comb begin
    pc_out      = cur_pc;
    pc_redirect = 1'b0;
    if (rst) begin
      pc_out = RESET_PC;
    end else if (any_redir) begin
      pc_out      = target;
      pc_redirect = 1'b1;
    end else if (pend_valid) begin
      pc_out      = pend_pc;
      pc_redirect = 1'b1;
    end else if (stall) begin
      pc_out = held_pc;
    end
  end

  assign redir_src = rst ? '0 : sel;

`ifdef PC_SEQUENCER_MISALIGN_EN
  assign misalign = pc_redirect && (pc_out[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (stall)  state_d = HOLD;
      HOLD:    if (!stall) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // A stalled redirect is parked in pend_pc; the newest one overwrites older ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_pc     <= RESET_PC;
      held_pc    <= RESET_PC;
      pend_valid <= 1'b0;
    end else if (!stall) begin
      cur_pc     <= seq_next(pc_out);
      held_pc    <= pc_out;
      pend_valid <= 1'b0;
    end else if (any_redir) begin
      pend_valid <= 1'b1;
      pend_pc    <= target;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected outputs are queued as each cycle is driven
// and compared by a negedge monitor; works with or without PC_SEQUENCER_MISALIGN_EN.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [1:0]  redir_valid;
  logic [63:0] redir_pc;
  logic [31:0] pc_out;
  logic        pc_redirect;
  logic [0:0]  redir_src;
  logic        misalign;

  typedef struct {
    logic [31:0] pc;
    logic        redir;
    logic [0:0]  src;
    logic        mis;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  bit   issued_500 = 1'b0;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .pc_out(pc_out), .pc_redirect(pc_redirect), .redir_src(redir_src), .misalign(misalign)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      if (pc_out !== e.pc) begin
        errors++;
        $display("FAIL pc_out @%0t: got %h expected %h", $time, pc_out, e.pc);
      end
      checks++;
      if (pc_redirect !== e.redir) begin
        errors++;
        $display("FAIL pc_redirect @%0t: got %b expected %b", $time, pc_redirect, e.redir);
      end
      checks++;
      if (redir_src !== e.src) begin
        errors++;
        $display("FAIL redir_src @%0t: got %0d expected %0d", $time, redir_src, e.src);
      end
      checks++;
      if (misalign !== e.mis) begin
        errors++;
        $display("FAIL misalign @%0t: got %b expected %b", $time, misalign, e.mis);
      end
    end
    if (!rst && !stall && pc_out === 32'h500) issued_500 = 1'b1;
  end

  // Drive one cycle of inputs and queue what the outputs must be during it.
  task automatic cyc(input logic r, input logic s, input logic [1:0] v,
                     input logic [31:0] p0, input logic [31:0] p1,
                     input logic [31:0] epc, input logic ered, input logic esrc,
                     input logic emis);
    exp_t e;
    rst         = r;
    stall       = s;
    redir_valid = v;
    redir_pc    = {p1, p0};
    e.pc    = epc;
    e.redir = ered;
    e.src   = esrc;
`ifdef PC_SEQUENCER_MISALIGN_EN
    e.mis   = emis;
`else
    e.mis   = 1'b0;
`endif
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 1, 2'b11, 32'h100, 32'h200, RST_PC, 0, 0, 0);
    cyc(1, 0, 2'b00, 0, 0, RST_PC, 0, 0, 0);
  endtask

  task automatic test_sequential();
    cyc(0, 0, 2'b00, 0, 0, 32'h4000_0000, 0, 0, 0);
    cyc(0, 0, 2'b00, 0, 0, 32'h4000_0004, 0, 0, 0);
    cyc(0, 0, 2'b00, 0, 0, 32'h4000_0008, 0, 0, 0);
  endtask

  task automatic test_stall_redirect();
    cyc(0, 1, 2'b00, 0, 0,        32'h4000_0008, 0, 0, 0);
    cyc(0, 1, 2'b10, 0, 32'h300,  32'h300, 1, 1, 0);
    cyc(0, 1, 2'b00, 0, 0,        32'h300, 1, 0, 0);
    cyc(0, 0, 2'b00, 0, 0,        32'h300, 1, 0, 0);
    cyc(0, 0, 2'b00, 0, 0,        32'h304, 0, 0, 0);
  endtask

  task automatic test_priority();
    cyc(0, 0, 2'b11, 32'h100, 32'h200, 32'h100, 1, 0, 0);
    cyc(0, 0, 2'b00, 0, 0,             32'h104, 0, 0, 0);
    cyc(0, 0, 2'b10, 32'h999, 32'h200, 32'h200, 1, 1, 0);
    cyc(0, 0, 2'b00, 0, 0,             32'h204, 0, 0, 0);
  endtask

  task automatic test_newest_wins();
    issued_500 = 1'b0;
    cyc(0, 1, 2'b01, 32'h500, 0, 32'h500, 1, 0, 0);
    cyc(0, 1, 2'b00, 0, 0,       32'h500, 1, 0, 0);
    cyc(0, 1, 2'b10, 0, 32'h600, 32'h600, 1, 1, 0);
    cyc(0, 0, 2'b00, 0, 0,       32'h600, 1, 0, 0);
    cyc(0, 0, 2'b00, 0, 0,       32'h604, 0, 0, 0);
    checks++;
    if (issued_500 !== 1'b0) begin
      errors++;
      $display("FAIL newest_wins: stale target 0x500 was issued (flag=%b, required 0)", issued_500);
    end
  endtask

  task automatic test_reset_pending();
    cyc(0, 1, 2'b01, 32'h700, 0, 32'h700, 1, 0, 0);
    cyc(0, 1, 2'b00, 0, 0, 32'h700, 1, 0, 0);
    cyc(1, 1, 2'b00, 0, 0, RST_PC, 0, 0, 0);
    cyc(0, 1, 2'b00, 0, 0, RST_PC, 0, 0, 0);
    cyc(0, 0, 2'b00, 0, 0, RST_PC, 0, 0, 0);
    cyc(0, 0, 2'b00, 0, 0, 32'h4000_0004, 0, 0, 0);
  endtask

  task automatic test_misalign();
    cyc(0, 0, 2'b01, 32'h102, 0, 32'h102, 1, 0, 1);
    cyc(0, 0, 2'b00, 0, 0,       32'h106, 0, 0, 0);
    cyc(0, 1, 2'b10, 0, 32'h20A, 32'h20A, 1, 1, 1);
    cyc(0, 0, 2'b00, 0, 0,       32'h20A, 1, 0, 1);
    cyc(0, 0, 2'b00, 0, 0,       32'h20E, 0, 0, 0);
  endtask

  task automatic test_wrap_long_stall();
    cyc(0, 0, 2'b01, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1, 0, 0);
    cyc(0, 0, 2'b00, 0, 0, 32'h0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 2'b00, 0, 0, 32'h0, 0, 0, 0);
    cyc(0, 0, 2'b00, 0, 0, 32'h4, 0, 0, 0);
    cyc(0, 0, 2'b00, 0, 0, 32'h8, 0, 0, 0);
  endtask

  initial begin
    rst         = 1'b1;
    stall       = 1'b0;
    redir_valid = 2'b00;
    redir_pc    = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_stall_redirect();
    test_priority();
    test_newest_wins();
    test_reset_pending();
    test_misalign();
    test_wrap_long_stall();
    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
